// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: owns the fetch PC, issues imem reads, buffers in-order responses with PCs for decode.
// Latency: imem response to inst_valid 1 cycle; redirect to first new request 1 cycle.
// Backpressure: a request is issued only while occupancy + inflight < DEPTH, so every kept response has a slot.
// Optional: define TINKER_FETCH_PERF_EN to add perf_starve_cnt / perf_flush_cnt outputs.

// tinker_fetch_fifo: generic flushable FIFO with registered storage and wrap-bit pointers.
// Latency: push visible at head the cycle after the write.
// Backpressure: none internally; the caller guarantees space (push with full only when popping).
module tinker_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop_fire;
  logic             push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_fire = pop_rdy && !empty && !flush;
  assign push_ok  = push_vld && !flush && (!full || pop_fire);
  assign head_vld = !empty;
  // Empty head reads as zero so the output is defined before any write.
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;

  // Pointer update; flush empties the queue and overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module tinker_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef TINKER_FETCH_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [AW:0] inflight;
  logic [AW:0] drop_cnt;
  logic [AW:0] occupancy;
  logic [AW+1:0] credit_used;
  logic        req_fire;
  logic        resp_vld;
  logic        push_vld;
  logic        head_vld;
  entry_t      push_dat;
  entry_t      head_dat;
  logic [31:0] redirect_pc_al;

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

  // Credit uses registered occupancy only, so inst_ready never reaches imem_req_valid.
  assign credit_used    = {1'b0, occupancy} + {1'b0, inflight};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (AW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_vld = imem_resp_valid && (inflight != '0);
  assign push_vld = resp_vld && !redirect_valid && (drop_cnt == '0);
  assign push_dat = '{data: imem_resp_data, pc: resp_pc};

  tinker_fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (inst_ready),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (occupancy)
  );

  assign inst_valid = head_vld;
  assign inst_data  = head_dat.data;
  assign inst_pc    = head_dat.pc;

  // Outstanding request count: +1 per accepted request, -1 per legal response.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (req_fire && !resp_vld) begin
      inflight <= inflight + CNT_ONE;
    end else if (!req_fire && resp_vld) begin
      inflight <= inflight - CNT_ONE;
    end
  end

  // Stale responses to discard after a redirect; a response in the redirect cycle is already dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= resp_vld ? (inflight - CNT_ONE) : inflight;
    end else if (resp_vld && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CNT_ONE;
    end
  end

  // Fetch PC advances per accepted request, response PC per kept word; both wrap mod 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      resp_pc  <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc_al;
      resp_pc  <= redirect_pc_al;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push_vld) resp_pc  <= resp_pc + 32'd4;
    end
  end

`ifdef TINKER_FETCH_PERF_EN
  // Saturating counters for decode starvation cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_starve_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (inst_ready && !inst_valid && (perf_starve_cnt != '1))
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: directed tables and sequences plus random traffic against a stream model.
// The model predicts the request address stream, the instruction stream, and the credit limit.
module tb_tinker_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  tinker_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h2000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  typedef struct { logic [31:0] addr; int due; int gen; } mreq_t;
  typedef struct { logic rdy; logic exp_rv; logic [31:0] exp_addr; logic exp_iv; logic [31:0] exp_pc; } vec_t;

  mreq_t       memq[$];
  int          cyc, last_due, mem_lat, cur_gen, live, avail;
  int          checks, errors;
  logic [31:0] exp_req_addr, exp_inst_pc;
  vec_t        tbl[10];

  // Memory contents: bijective hash of the address, so every PC has a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    cyc = 0; last_due = -1; cur_gen = 0; live = 0; avail = 0;
    exp_req_addr = 32'h2000; exp_inst_pc = 32'h2000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    inst_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("reset_req_valid", imem_req_valid, 32'(1'b0));
    model_reset();
  endtask

  // One clock cycle: drive inputs and the memory response, then check against the model.
  task automatic step(input logic rdy, input logic qrdy, input logic redir, input logic [31:0] rpc);
    mreq_t m;
    logic  resp_now;
    int    resp_gen, stale, due;
    logic  exp_rv;
    @(negedge clk);
    reset = 1'b0; inst_ready = rdy; imem_req_ready = qrdy;
    redirect_valid = redir; redirect_pc = rpc;
    resp_now = 1'b0; resp_gen = -1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      resp_now = 1'b1; resp_gen = m.gen;
      imem_resp_valid = 1'b1; imem_resp_data = mem_word(m.addr);
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = 32'hDEAD_BEEF;
    end
    #1;
    stale = 0;
    foreach (memq[i]) if (memq[i].gen != cur_gen) stale++;
    if (resp_now && resp_gen != cur_gen) stale++;
    exp_rv = !redir && (live + stale < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("inst_valid", 32'(inst_valid), 32'(avail > 0));
    if (inst_valid && avail > 0) begin
      chk("inst_pc", inst_pc, exp_inst_pc);
      chk("inst_data", inst_data, mem_word(exp_inst_pc));
    end
    if (imem_req_valid && qrdy) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: imem_req_addr, due: due, gen: cur_gen});
    end
    if (redir) begin
      cur_gen++; live = 0; avail = 0;
      exp_req_addr = {rpc[31:2], 2'b00};
      exp_inst_pc  = {rpc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && qrdy) begin
        chk("req_addr", imem_req_addr, exp_req_addr);
        exp_req_addr += 32'd4;
        live++;
      end
      if (inst_valid && rdy && avail > 0) begin
        exp_inst_pc += 32'd4; avail--; live--;
      end
      if (resp_now && resp_gen == cur_gen) avail++;
    end
    cyc++;
  endtask

  initial begin
    int found;
    logic [31:0] rpc;
    checks = 0; errors = 0; mem_lat = 1;
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    model_reset();

    // Streaming fetch with a 1-cycle memory and decode always ready.
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
      end
      chk("t1_addr", imem_req_addr, 32'h2000 + 32'(4 * k));
      if (k >= 2) begin
        chk("t1_thru_valid", 32'(inst_valid), 32'h1);
        chk("t1_pc", inst_pc, 32'h2000 + 32'(4 * (k - 2)));
      end
    end

    // Credit limit with decode stalled, then a single pop frees one slot.
    tbl[0] = '{1'b0, 1'b1, 32'h2000, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h2004, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h2008, 1'b1, 32'h2000};
    tbl[3] = '{1'b0, 1'b1, 32'h200C, 1'b1, 32'h2000};
    tbl[4] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2000};
    tbl[5] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2000};
    tbl[6] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2000};
    tbl[7] = '{1'b0, 1'b1, 32'h2010, 1'b1, 32'h2004};
    tbl[8] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2004};
    tbl[9] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h2004};
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      chk("t2_req_valid", 32'(imem_req_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk("t2_req_addr", imem_req_addr, tbl[i].exp_addr);
      chk("t2_inst_valid", 32'(inst_valid), 32'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) chk("t2_inst_pc", inst_pc, tbl[i].exp_pc);
    end

    // Redirect with three requests outstanding to a 3-cycle memory.
    do_reset();
    mem_lat = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h3002);
    chk("t3_no_req_in_redirect", 32'(imem_req_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t3_req_addr", imem_req_addr, 32'h3000);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (inst_valid) begin
        found = 1;
        chk("t3_first_pc", inst_pc, 32'h3000);
      end
    end
    chk("t3_seen", 32'(found), 32'h1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a response and a pop.
    do_reset();
    mem_lat = 2;
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h4000);
    chk("t4_resp_in_redirect", 32'(imem_resp_valid), 32'h1);
    chk("t4_pop_in_redirect", 32'(inst_valid), 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_empty_after", 32'(inst_valid), 32'h0);
    chk("t4_req_addr", imem_req_addr, 32'h4000);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with buffered words and requests in flight.
    do_reset();
    mem_lat = 3;
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_pre_valid", 32'(inst_valid), 32'h1);
    do_reset();
    mem_lat = 50;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_inst_valid", 32'(inst_valid), 32'h0);
    chk("t5_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t5_req_addr", imem_req_addr, 32'h2000);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t5_credit_free", 32'(imem_req_valid), 32'h1);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_credit_full", 32'(imem_req_valid), 32'h0);

    // Redirect near the top of the address space; fetch wraps to zero.
    do_reset();
    mem_lat = 1;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_addr0", imem_req_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_addr1", imem_req_addr, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_pc0", inst_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_pc1", inst_pc, 32'h0000_0000);

    // Random traffic: variable latency, stalls on both sides, occasional redirects.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + ($urandom & 32'hF);
      else rpc = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 29) == 0, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
